// File: rtl/triangle_assembler_if.sv
// Vertex-in / triangle-out handshake bundle for the triangle assembler.
interface triangle_assembler_if;
    logic                   valid_in;
    logic                   ready_out;
    logic [3:0][31:0]       position_in;
    logic [2:0][31:0]       normal_in;
    logic [11:0]            material_in;
    logic                   valid_out;
    logic                   ready_in;
    logic [2:0][3:0][31:0]  position_out;
    logic [2:0][31:0]       normal_out;
    logic [11:0]            material_out;

    modport slave (
        input  valid_in, position_in, normal_in, material_in, ready_in,
        output ready_out, valid_out, position_out, normal_out, material_out
    );

    modport master (
        output valid_in, position_in, normal_in, material_in, ready_in,
        input  ready_out, valid_out, position_out, normal_out, material_out
    );
endinterface

// File: rtl/triangle_assembler.sv
// Groups incoming vertices into list/strip triangles and holds each one until
// the rasterizer setup stage takes it; provoking-vertex normal/material forwarded.
module triangle_assembler #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   mode_in,
    input  logic                   restart_in,
    triangle_assembler_if.slave    bus,
    output logic [COUNT_WIDTH-1:0] triangle_count_out
);
    typedef enum logic {COLLECT, HOLD} state_t;

    state_t           state;
    logic [1:0]       count;
    logic             parity;
    logic [3:0][31:0] s0;
    logic [3:0][31:0] s1;

    logic             accept;
    logic [1:0]       count_eff;
    logic             parity_eff;
    logic             swap_ab;

    // A restart coinciding with an accept clears history before the vertex lands.
    always_comb begin
        accept     = bus.valid_in && bus.ready_out;
        count_eff  = restart_in ? 2'd0 : count;
        parity_eff = restart_in ? 1'b0 : parity;
        swap_ab    = mode_in && parity_eff;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state              <= COLLECT;
            count              <= '0;
            parity             <= 1'b0;
            s0                 <= '0;
            s1                 <= '0;
            bus.ready_out      <= 1'b1;
            bus.valid_out      <= 1'b0;
            bus.position_out   <= '0;
            bus.normal_out     <= '0;
            bus.material_out   <= '0;
            triangle_count_out <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    count  <= count_eff;
                    parity <= parity_eff;
                    if (accept) begin
                        if (count_eff == 2'd2) begin
                            // Odd strip triangles swap a/b to keep a consistent winding.
                            bus.position_out[0] <= swap_ab ? s1 : s0;
                            bus.position_out[1] <= swap_ab ? s0 : s1;
                            bus.position_out[2] <= bus.position_in;
                            bus.normal_out      <= bus.normal_in;
                            bus.material_out    <= bus.material_in;
                            bus.valid_out       <= 1'b1;
                            bus.ready_out       <= 1'b0;
                            state               <= HOLD;
                            if (mode_in) begin
                                s0     <= s1;
                                s1     <= bus.position_in;
                                parity <= ~parity_eff;
                            end else begin
                                count <= '0;
                            end
                        end else if (count_eff == 2'd0) begin
                            s0    <= bus.position_in;
                            count <= 2'd1;
                        end else begin
                            s1    <= bus.position_in;
                            count <= 2'd2;
                        end
                    end
                end
                HOLD: begin
                    if (restart_in) begin
                        count  <= '0;
                        parity <= 1'b0;
                    end
                    if (bus.ready_in) begin
                        bus.valid_out      <= 1'b0;
                        bus.ready_out      <= 1'b1;
                        triangle_count_out <= triangle_count_out + COUNT_WIDTH'(1);
                        state              <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end
endmodule
